// File: rtl/mem_stage_if.sv
// Signal bundle around the MEM stage: EX-side inputs, data-memory port and MEM/WB outputs.
// The slave modport is the stage itself; master is whatever surrounds it (EX, memory, WB).
interface mem_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rd_data;
    logic        reg_write;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [5:0]  wb_opcode;
    logic        err;

    modport master (
        output in_valid, alu_result, opcode, rd, mem_read, mem_write, rd_data, reg_write,
        output dmem_ack, dmem_rdata,
        input  in_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  wb_valid, wb_data, wb_rd, wb_reg_write, wb_opcode, err
    );

    modport slave (
        input  in_valid, alu_result, opcode, rd, mem_read, mem_write, rd_data, reg_write,
        input  dmem_ack, dmem_rdata,
        output in_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output wb_valid, wb_data, wb_rd, wb_reg_write, wb_opcode, err
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues LW/SW on a req/ack data-memory port with a bounded wait
// and drives a registered MEM/WB bundle; non-memory ops pass through in one cycle.
module mem_stage #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam bit               TIMEOUT_EN = (WAIT_MAX != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WAIT_MAX - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;

    logic        req_p1, req_nxt;
    logic        we_p1, we_nxt;
    logic [31:0] addr_p1, addr_nxt;
    logic [31:0] wdata_p1, wdata_nxt;
    logic        wb_valid_p1, wb_valid_nxt;
    logic [31:0] wb_data_p1, wb_data_nxt;
    logic [4:0]  wb_rd_p1, wb_rd_nxt;
    logic        wb_rw_p1, wb_rw_nxt;
    logic [5:0]  wb_op_p1, wb_op_nxt;
    logic        err_p1, err_nxt;

    logic [5:0]  acc_op_p1;
    logic [4:0]  acc_rd_p1;
    logic        acc_rw_p1;
    logic [31:0] acc_alu_p1;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    function automatic logic is_illegal(input logic rd_req, input logic wr_req);
        return rd_req && wr_req;
    endfunction

    function automatic logic timed_out(input logic [CNT_W-1:0] count);
        return TIMEOUT_EN && (count == CNT_LAST);
    endfunction

    assign bus.in_ready = (state == IDLE);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        accept       = 1'b0;
        req_nxt      = req_p1;
        we_nxt       = we_p1;
        addr_nxt     = addr_p1;
        wdata_nxt    = wdata_p1;
        wb_valid_nxt = 1'b0;
        err_nxt      = 1'b0;
        wb_data_nxt  = wb_data_p1;
        wb_rd_nxt    = wb_rd_p1;
        wb_rw_nxt    = wb_rw_p1;
        wb_op_nxt    = wb_op_p1;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (!bus.mem_read && !bus.mem_write) begin
                        wb_valid_nxt = 1'b1;
                        wb_data_nxt  = bus.alu_result;
                        wb_rd_nxt    = bus.rd;
                        wb_rw_nxt    = bus.reg_write;
                        wb_op_nxt    = bus.opcode;
                    end else if (is_illegal(bus.mem_read, bus.mem_write) ||
                                 is_misaligned(bus.alu_result)) begin
                        // Rejected before touching memory; retired as a non-writing error.
                        wb_valid_nxt = 1'b1;
                        err_nxt      = 1'b1;
                        wb_data_nxt  = bus.alu_result;
                        wb_rd_nxt    = bus.rd;
                        wb_rw_nxt    = 1'b0;
                        wb_op_nxt    = bus.opcode;
                    end else begin
                        state_nxt = ACCESS;
                        cnt_nxt   = '0;
                        req_nxt   = 1'b1;
                        we_nxt    = bus.mem_write;
                        addr_nxt  = bus.alu_result;
                        wdata_nxt = bus.rd_data;
                    end
                end
            end
            ACCESS: begin
                if (bus.dmem_ack) begin
                    state_nxt    = IDLE;
                    req_nxt      = 1'b0;
                    wb_valid_nxt = 1'b1;
                    wb_rd_nxt    = acc_rd_p1;
                    wb_op_nxt    = acc_op_p1;
                    if (we_p1) begin
                        wb_data_nxt = acc_alu_p1;
                        wb_rw_nxt   = 1'b0;
                    end else begin
                        wb_data_nxt = bus.dmem_rdata;
                        wb_rw_nxt   = acc_rw_p1;
                    end
                end else if (timed_out(cnt)) begin
                    // Ack is checked first, so an ack on the last allowed cycle still completes.
                    state_nxt    = IDLE;
                    req_nxt      = 1'b0;
                    wb_valid_nxt = 1'b1;
                    err_nxt      = 1'b1;
                    wb_data_nxt  = acc_alu_p1;
                    wb_rd_nxt    = acc_rd_p1;
                    wb_rw_nxt    = 1'b0;
                    wb_op_nxt    = acc_op_p1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage register: control state plus every externally visible output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_p1      <= 1'b0;
            we_p1       <= 1'b0;
            addr_p1     <= '0;
            wdata_p1    <= '0;
            wb_valid_p1 <= 1'b0;
            wb_data_p1  <= '0;
            wb_rd_p1    <= '0;
            wb_rw_p1    <= 1'b0;
            wb_op_p1    <= '0;
            err_p1      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            req_p1      <= req_nxt;
            we_p1       <= we_nxt;
            addr_p1     <= addr_nxt;
            wdata_p1    <= wdata_nxt;
            wb_valid_p1 <= wb_valid_nxt;
            wb_data_p1  <= wb_data_nxt;
            wb_rd_p1    <= wb_rd_nxt;
            wb_rw_p1    <= wb_rw_nxt;
            wb_op_p1    <= wb_op_nxt;
            err_p1      <= err_nxt;
        end
    end

    // Accepted bundle, only consumed while an access is outstanding, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_op_p1  <= bus.opcode;
            acc_rd_p1  <= bus.rd;
            acc_rw_p1  <= bus.reg_write;
            acc_alu_p1 <= bus.alu_result;
        end
    end

    assign bus.dmem_req     = req_p1;
    assign bus.dmem_we      = we_p1;
    assign bus.dmem_addr    = addr_p1;
    assign bus.dmem_wdata   = wdata_p1;
    assign bus.wb_valid     = wb_valid_p1;
    assign bus.wb_data      = wb_data_p1;
    assign bus.wb_rd        = wb_rd_p1;
    assign bus.wb_reg_write = wb_rw_p1;
    assign bus.wb_opcode    = wb_op_p1;
    assign bus.err          = err_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the stage.
module tb_mem_stage;
    localparam int WAIT_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mem_stage_if bus();

    mem_stage #(.WAIT_MAX(WAIT_MAX), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: one outstanding access at most, described by what is pending and how long it waited.
    bit          m_busy;
    int          m_waited;
    bit          m_store;
    logic [31:0] m_addr, m_wdata;
    logic [4:0]  m_rd;
    logic [5:0]  m_op;
    bit          m_rw;

    logic        e_req, e_we, e_wb_valid, e_err, e_wb_rw;
    logic [31:0] e_addr, e_wdata, e_wb_data;
    logic [4:0]  e_wb_rd;
    logic [5:0]  e_wb_op;
    bit          e_known;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_waited = 0;
        e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
        e_wb_valid = 0; e_err = 0; e_wb_data = 0; e_wb_rd = 0; e_wb_rw = 0; e_wb_op = 0;
        e_known = 1;
    endtask

    task automatic model_step();
        e_wb_valid = 0;
        e_err      = 0;
        if (!m_busy) begin
            if (bus.in_valid) begin
                if (!bus.mem_read && !bus.mem_write) begin
                    e_wb_valid = 1; e_wb_data = bus.alu_result; e_wb_rd = bus.rd;
                    e_wb_op = bus.opcode; e_wb_rw = bus.reg_write; e_known = 1;
                end else if ((bus.mem_read && bus.mem_write) || (bus.alu_result % 4 != 0)) begin
                    e_wb_valid = 1; e_err = 1; e_wb_data = bus.alu_result; e_wb_rd = bus.rd;
                    e_wb_op = bus.opcode; e_wb_rw = 0; e_known = 1;
                end else begin
                    m_busy = 1; m_waited = 0; m_store = bus.mem_write;
                    m_addr = bus.alu_result; m_wdata = bus.rd_data;
                    m_rd = bus.rd; m_op = bus.opcode; m_rw = bus.reg_write;
                    e_req = 1; e_we = bus.mem_write; e_addr = bus.alu_result; e_wdata = bus.rd_data;
                end
            end
        end else if (bus.dmem_ack) begin
            m_busy = 0; e_req = 0; e_wb_valid = 1; e_known = 1;
            e_wb_rd = m_rd; e_wb_op = m_op;
            e_wb_data = m_store ? m_addr : bus.dmem_rdata;
            e_wb_rw   = m_store ? 1'b0 : m_rw;
        end else begin
            m_waited++;
            if (WAIT_MAX != 0 && m_waited == WAIT_MAX) begin
                m_busy = 0; e_req = 0; e_wb_valid = 1; e_err = 1; e_wb_rw = 0; e_known = 0;
            end
        end
    endtask

    task automatic compare();
        chk("in_ready", bus.in_ready, !m_busy);
        chk("dmem_req", bus.dmem_req, e_req);
        if (e_req) begin
            chk("dmem_we", bus.dmem_we, e_we);
            chk("dmem_addr", bus.dmem_addr, e_addr);
            chk("dmem_wdata", bus.dmem_wdata, e_wdata);
        end
        chk("wb_valid", bus.wb_valid, e_wb_valid);
        chk("err", bus.err, e_err);
        chk("wb_reg_write", bus.wb_reg_write, e_wb_rw);
        if (e_known) begin
            chk("wb_data", bus.wb_data, e_wb_data);
            chk("wb_rd", bus.wb_rd, e_wb_rd);
            chk("wb_opcode", bus.wb_opcode, e_wb_op);
        end
    endtask

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        compare();
    end

    task automatic put(input logic [5:0] op, input logic [31:0] alu, input logic [4:0] rd,
                       input logic mr, input logic mw, input logic [31:0] wd, input logic rw);
        bus.in_valid = 1; bus.opcode = op; bus.alu_result = alu; bus.rd = rd;
        bus.mem_read = mr; bus.mem_write = mw; bus.rd_data = wd; bus.reg_write = rw;
    endtask

    task automatic clear_in();
        bus.in_valid = 0; bus.mem_read = 0; bus.mem_write = 0;
    endtask

    initial begin
        logic rdy_prev;
        logic [31:0] a;
        int n, kind;

        clear_in();
        bus.opcode = 0; bus.alu_result = 0; bus.rd = 0; bus.rd_data = 0; bus.reg_write = 0;
        bus.dmem_ack = 0; bus.dmem_rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_req", bus.dmem_req, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_dmem_addr", bus.dmem_addr, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst_n = 1;
        @(negedge clk);

        put(6'h00, 32'h30, 5'd5, 0, 0, 32'h0, 1);
        @(negedge clk); clear_in();
        chk("add_valid", bus.wb_valid, 1);
        chk("add_data", bus.wb_data, 32'h30);
        chk("add_rd", bus.wb_rd, 5);
        chk("add_rw", bus.wb_reg_write, 1);
        chk("add_req", bus.dmem_req, 0);
        @(negedge clk);
        chk("add_pulse", bus.wb_valid, 0);

        put(6'h23, 32'h100, 5'd8, 1, 0, 32'h0, 1);
        @(negedge clk); clear_in();
        chk("lw_req", bus.dmem_req, 1);
        chk("lw_we", bus.dmem_we, 0);
        chk("lw_addr", bus.dmem_addr, 32'h100);
        chk("lw_ready", bus.in_ready, 0);
        repeat (3) begin
            @(negedge clk);
            chk("lw_wait_ready", bus.in_ready, 0);
            chk("lw_wait_req", bus.dmem_req, 1);
        end
        bus.dmem_ack = 1; bus.dmem_rdata = 32'hDEADBEEF;
        @(negedge clk); bus.dmem_ack = 0;
        chk("lw_valid", bus.wb_valid, 1);
        chk("lw_data", bus.wb_data, 32'hDEADBEEF);
        chk("lw_rd", bus.wb_rd, 8);
        chk("lw_rw", bus.wb_reg_write, 1);
        chk("lw_done_ready", bus.in_ready, 1);

        put(6'h2B, 32'h204, 5'd0, 0, 1, 32'h12345678, 1);
        @(negedge clk); clear_in();
        chk("sw_we", bus.dmem_we, 1);
        chk("sw_wdata", bus.dmem_wdata, 32'h12345678);
        chk("sw_addr", bus.dmem_addr, 32'h204);
        bus.dmem_ack = 1;
        @(negedge clk); bus.dmem_ack = 0;
        chk("sw_valid", bus.wb_valid, 1);
        chk("sw_rw", bus.wb_reg_write, 0);
        chk("sw_data", bus.wb_data, 32'h204);

        put(6'h23, 32'h102, 5'd9, 1, 0, 32'h0, 1);
        @(negedge clk); clear_in();
        chk("mis_req", bus.dmem_req, 0);
        chk("mis_err", bus.err, 1);
        chk("mis_valid", bus.wb_valid, 1);
        chk("mis_rw", bus.wb_reg_write, 0);
        chk("mis_ready", bus.in_ready, 1);
        @(negedge clk);
        chk("mis_err_pulse", bus.err, 0);

        put(6'h23, 32'h300, 5'd10, 1, 0, 32'h0, 1);
        @(negedge clk); clear_in();
        n = 0;
        while (bus.dmem_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("to_req_cycles", n, 4);
        chk("to_err", bus.err, 1);
        chk("to_valid", bus.wb_valid, 1);
        chk("to_rw", bus.wb_reg_write, 0);
        bus.dmem_ack = 1;
        @(negedge clk); bus.dmem_ack = 0;
        chk("late_ack_valid", bus.wb_valid, 0);
        chk("late_ack_req", bus.dmem_req, 0);

        put(6'h23, 32'h400, 5'd11, 1, 0, 32'h0, 1);
        @(negedge clk); clear_in();
        @(negedge clk);
        @(posedge clk); #2 rst_n = 0;
        #1 chk("rst_mid_req", bus.dmem_req, 0);
        @(negedge clk); rst_n = 1; bus.dmem_ack = 1; bus.dmem_rdata = 32'hBAD;
        @(negedge clk); bus.dmem_ack = 0;
        chk("rst_ack_ignored", bus.wb_valid, 0);
        put(6'h00, 32'h44, 5'd3, 0, 0, 32'h0, 1);
        @(negedge clk); clear_in();
        chk("post_rst_valid", bus.wb_valid, 1);
        chk("post_rst_data", bus.wb_data, 32'h44);
        chk("post_rst_rd", bus.wb_rd, 3);

        rdy_prev = bus.in_ready;
        for (int c = 0; c < 3000; c++) begin
            if (!(bus.in_valid && !rdy_prev)) begin
                if ($urandom_range(99) < 65) begin
                    kind = $urandom_range(9);
                    a = $urandom;
                    if (kind >= 4 && $urandom_range(99) < 85) a = a & 32'hFFFF_FFFC;
                    put(6'($urandom), a, 5'($urandom), kind inside {[4:6], 9}, kind >= 7,
                        $urandom, 1'($urandom));
                end else begin
                    clear_in();
                end
            end
            bus.dmem_ack   = bus.dmem_req ? ($urandom_range(99) < 35) : ($urandom_range(99) < 8);
            bus.dmem_rdata = $urandom;
            rdy_prev = bus.in_ready;
            @(negedge clk);
        end
        clear_in();
        bus.dmem_ack = 0;
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
